mux16_1_struct: RTL and testbench
=================================

// Module: mux16_1_struct
// PURPOSE
//   16:1 single-bit multiplexer built structurally as a two-level tree of 4:1 muxes.
//   Five 4:1 cells in total; each 4:1 cell is three 2:1 primitives.
//   Provides a zero-latency combinational result and a registered copy of it.
//   Used as a reusable bit-select leaf in datapath and bit-steering logic.
// PARAMETERS
//   none -- width fixed at 16 inputs / 4 select bits (constants in shared package)
// PORTS
//   clk     in   1   system clock; sole clock, output register updates on rising edge
//   rst_n   in   1   reset, asynchronous assert, active-low
//   in      in   16  data inputs; in[k] is candidate k
//   s       in   4   select; unsigned index 0..15
//   y       out  1   combinational output = in[s], zero latency
//   y_q     out  1   registered output = y sampled at rising clk
// BEHAVIOUR
//   - y = in[s] for every s in 0..15; purely combinational, no clock involvement.
//   - All 16 select codes are legal; no default/illegal case exists.
//   - Tree decode:
//     - Level 1: cell j (j=0..3) selects in[4j+s[1:0]].
//     - Level 2: one 4:1 cell selects level-1 output s[3:2].
//     - Net result: s[3:2] picks the group, s[1:0] picks the bit within the group.
//   - Inside each 4:1 cell:
//     - Two 2:1 muxes on s[0] pick (d0,d1) and (d2,d3).
//     - A third 2:1 mux on s[1] picks between those two results.
//     - 2:1 function: o = sel ? b : a.
//   - X/Z on s: y follows Verilog ?: semantics (X unless both candidates agree); no special handling.
//   - y_q behaviour:
//     - rst_n low: y_q = 0 immediately, asynchronously, independent of clk.
//     - rst_n high: y_q <= y on each rising clk edge; latency exactly 1 cycle.
//     - rst_n deasserting: first capture occurs on the first rising edge after rst_n goes high.
//   - y is unaffected by rst_n; it is valid during reset.
//   - Simultaneous change of in and s: y settles to in_new[s_new] combinationally.
// STRUCTURE
//   - Shared package mux_pkg:
//     - MUX_N_IN = 16
//     - MUX_SEL_W = 4
//     - MUX_GRP = 4 (inputs per 4:1 cell)
//   - Sub-module mux4_1_cell:
//     - ports d[3:0], sel[1:0], o
//     - internally three 2:1 muxes
//     - instantiated 5 times: 4 at level 1, 1 at level 2
//   - Top level holds only the cell instances, the interconnect wires and the y_q flop.
//   - No behavioural case statement for the select path.
// TESTING
//   1. One-hot walk: for k=0..15 set in=16'h1<<k, s=k -> y=1.
//      Next clk: y_q=1.
//   2. Inverse walk: for k=0..15 set in=~(16'h1<<k), s=k -> y=0.
//      Also s=(k+1)%16 -> y=1, which catches adjacent-index swaps.
//   3. Group decode: in=16'hF000, s=4'b1100..4'b1111 -> y=1.
//      Same in with s=4'b0000..4'b1011 -> y=0.
//   4. Reset: y_q=1 (in=16'h8000, s=15), then drop rst_n mid-cycle -> y_q=0 at once, y stays 1.
//      Raise rst_n -> y_q=1 after the next rising clk edge.
//   5. Latency: toggle s 0<->1 each cycle with in=16'h0002 -> y alternates 0,1.
//      y_q is the same pattern delayed exactly one cycle.
//   6. Exhaustive: all 16 s values x 256 random in words.
//      y must equal the reference model in[s]; y_q must equal y one cycle earlier.

Source files
------------

// File: rtl/mux16_1_struct_pkg.sv
// Shared constants for the 16:1 structural mux tree.
package mux_pkg;

  localparam int unsigned MUX_N_IN  = 16;  // number of data inputs
  localparam int unsigned MUX_SEL_W = 4;   // select width
  localparam int unsigned MUX_GRP   = 4;   // inputs per 4:1 cell
  localparam int unsigned MUX_CELL_SEL_W = 2;  // select bits consumed per tree level

endpackage

// File: rtl/mux16_1_struct_if.sv
// Bus bundle for the 16:1 mux: data/select in, combinational and registered result out.
interface mux16_1_struct_if;
  import mux_pkg::*;

  logic [MUX_N_IN-1:0]  in;
  logic [MUX_SEL_W-1:0] s;
  logic                 y;
  logic                 y_q;

  // Driver side: supplies data and select, observes results.
  modport master (
    output in,
    output s,
    input  y,
    input  y_q
  );

  // Mux side: consumes data and select, produces results.
  modport slave (
    input  in,
    input  s,
    output y,
    output y_q
  );

endinterface

// File: rtl/mux16_1_struct_mux4_1_cell.sv
// 4:1 single-bit mux cell built from three 2:1 stages.
module mux4_1_cell
  import mux_pkg::*;
(
  input  logic [MUX_GRP-1:0]        d,
  input  logic [MUX_CELL_SEL_W-1:0] sel,
  output logic                      o
);

  logic lo_pair;
  logic hi_pair;

  // First stage: sel[0] picks within each pair; plain ?: so X on sel resolves
  // only when both candidates agree.
  assign lo_pair = sel[0] ? d[1] : d[0];
  assign hi_pair = sel[0] ? d[3] : d[2];

  // Second stage: sel[1] picks between the pairs.
  assign o = sel[1] ? hi_pair : lo_pair;

endmodule

// File: rtl/mux16_1_struct.sv
// 16:1 single-bit mux as a two-level tree of 4:1 cells, plus a registered copy.
module mux16_1_struct
  import mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mux16_1_struct_if.slave  bus
);

  localparam int unsigned NumCells = MUX_N_IN / MUX_GRP;

  logic [NumCells-1:0] grp_y;
  logic                y_root;
  logic                y_q_d;
  logic                y_q_q;

  // Level 1: cell j resolves in[4j + s[1:0]].
  for (genvar j = 0; j < NumCells; j++) begin : g_level1
    mux4_1_cell u_cell (
      .d   (bus.in[MUX_GRP*j +: MUX_GRP]),
      .sel (bus.s[MUX_CELL_SEL_W-1:0]),
      .o   (grp_y[j])
    );
  end

  // Level 2: s[3:2] picks the group.
  mux4_1_cell u_root (
    .d   (grp_y),
    .sel (bus.s[MUX_SEL_W-1:MUX_CELL_SEL_W]),
    .o   (y_root)
  );

  assign bus.y = y_root;

  // Registered copy simply tracks the combinational result.
  always_comb begin
    y_q_d = y_root;
  end

  // Output register; reset clears it asynchronously while y stays live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q <= 1'b0;
    end else begin
      y_q_q <= y_q_d;
    end
  end

  assign bus.y_q = y_q_q;

endmodule

// File: tb/tb_mux16_1_struct.sv
// Self-checking bench for mux16_1_struct: directed walks plus randomized sweep.
module tb_mux16_1_struct;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] in_v;
  logic [3:0]  s_v;

  mux16_1_struct_if bus ();

  assign bus.in = in_v;
  assign bus.s  = s_v;

  mux16_1_struct dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit s of the input word, by shift arithmetic.
  function automatic logic ref_y(input logic [15:0] w, input logic [3:0] sel);
    logic [15:0] sh;
    sh = w >> sel;
    return sh[0];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs, let them settle, check combinational output.
  task automatic apply(input string tag, input logic [15:0] w, input logic [3:0] sel);
    in_v = w;
    s_v  = sel;
    #1;
    check(tag, bus.y, ref_y(w, sel));
  endtask

  // Advance one rising edge and check y_q against the pre-edge model value.
  task automatic tick(input string tag);
    logic exp;
    exp = rst_n ? ref_y(in_v, s_v) : 1'b0;
    @(posedge clk);
    #1;
    check(tag, bus.y_q, exp);
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  sel;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    in_v   = 16'h0000;
    s_v    = 4'd0;

    // Reset state, and y valid during reset.
    #2;
    check("reset_yq", bus.y_q, 1'b0);
    apply("reset_y_live", 16'h0001, 4'd0);
    check("reset_y_is_one", bus.y, 1'b1);
    tick("reset_hold_yq");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. One-hot walk.
    for (int k = 0; k < 16; k++) begin
      w = 16'h1 << k;
      sel = 4'(k);
      apply("onehot_y", w, sel);
      check("onehot_y_one", bus.y, 1'b1);
      tick("onehot_yq");
    end

    // 2. Inverse walk, plus neighbour index.
    for (int k = 0; k < 16; k++) begin
      w = ~(16'h1 << k);
      apply("inv_y", w, 4'(k));
      check("inv_y_zero", bus.y, 1'b0);
      apply("inv_adj_y", w, 4'((k + 1) % 16));
      check("inv_adj_y_one", bus.y, 1'b1);
    end

    // 3. Group decode.
    for (int k = 0; k < 16; k++) begin
      apply("grp_y", 16'hF000, 4'(k));
      check("grp_y_const", bus.y, (k >= 12) ? 1'b1 : 1'b0);
    end

    // 4. Async reset mid-cycle.
    apply("rst_pre_y", 16'h8000, 4'd15);
    tick("rst_pre_yq");
    check("rst_pre_yq_one", bus.y_q, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_yq", bus.y_q, 1'b0);
    check("rst_y_live", bus.y, 1'b1);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_release_wait", bus.y_q, 1'b0);
    tick("rst_first_capture");
    check("rst_first_capture_one", bus.y_q, 1'b1);

    // 5. Latency: s toggles 0<->1 with in=0002.
    for (int k = 0; k < 8; k++) begin
      apply("lat_y", 16'h0002, 4'(k % 2));
      check("lat_y_pattern", bus.y, (k % 2 == 1) ? 1'b1 : 1'b0);
      tick("lat_yq");
      check("lat_yq_pattern", bus.y_q, (k % 2 == 1) ? 1'b1 : 1'b0);
    end

    // 6. Randomized sweep over every select value.
    for (int sv = 0; sv < 16; sv++) begin
      for (int n = 0; n < 256; n++) begin
        w = 16'($urandom);
        apply("rand_y", w, 4'(sv));
        tick("rand_yq");
      end
    end

    // Simultaneous change of in and s settles to new selection.
    apply("simul_a", 16'h00FF, 4'd3);
    apply("simul_b", 16'hFF00, 4'd12);
    check("simul_b_one", bus.y, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
